// File: rtl/cim_level_decoder.sv
// cim_level_decoder: recovers a CiM level by popcounting the query/seed XOR one chunk per cycle
module cim_level_decoder #(
  parameter int HVDimension   = 512,
  parameter int ChunkWidth    = 64,
  parameter int FlipsPerLevel = 16,
  parameter int NumLevels     = 32,
  parameter int CountWidth    = $clog2(HVDimension + 1),
  localparam int LevelWidth   = $clog2(NumLevels)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [HVDimension-1:0] seed_hv_i,
  input  logic [HVDimension-1:0] hv_i,
  input  logic                   hv_valid_i,
  output logic                   hv_ready_o,
  output logic [CountWidth-1:0]  flip_count_o,
  output logic [LevelWidth-1:0]  level_o,
  output logic                   level_valid_o,
  input  logic                   level_ready_i,
  output logic                   busy_o
);
  localparam int NumChunks = HVDimension / ChunkWidth;
  localparam int ChunkIdxW = NumChunks > 1 ? $clog2(NumChunks) : 1;
  localparam int Shift     = $clog2(FlipsPerLevel);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e state_q, state_d;

  logic [HVDimension-1:0] diff_q;
  logic [CountWidth-1:0]  acc_q, flip_q, pop, sum;
  logic [ChunkIdxW-1:0]   chunk_q;
  logic [LevelWidth-1:0]  level_q, level_d;
  logic [CountWidth:0]    rnd, lvl;
  logic                   last;

  always_comb begin
    pop = '0;
    for (int i = 0; i < ChunkWidth; i++) pop = pop + CountWidth'(diff_q[i]);
  end

  // round to nearest level, then saturate at the top level
  always_comb begin
    sum     = acc_q + pop;
    rnd     = {1'b0, sum} + (CountWidth + 1)'(FlipsPerLevel / 2);
    lvl     = rnd >> Shift;
    level_d = lvl > (CountWidth + 1)'(NumLevels - 1) ? LevelWidth'(NumLevels - 1) : lvl[LevelWidth-1:0];
    last    = chunk_q == ChunkIdxW'(NumChunks - 1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = hv_valid_i ? BUSY : IDLE;
      BUSY:    state_d = last ? DONE : BUSY;
      DONE:    state_d = level_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      diff_q  <= '0;
      acc_q   <= '0;
      chunk_q <= '0;
      flip_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && hv_valid_i) begin
        diff_q  <= hv_i ^ seed_hv_i;
        acc_q   <= '0;
        chunk_q <= '0;
      end else if (state_q == BUSY) begin
        diff_q  <= diff_q >> ChunkWidth;
        acc_q   <= sum;
        chunk_q <= chunk_q + 1'b1;
        if (last) begin
          flip_q  <= sum;
          level_q <= level_d;
        end
      end
    end
  end

  assign hv_ready_o    = state_q == IDLE;
  assign busy_o        = state_q != IDLE;
  assign level_valid_o = state_q == DONE;
  assign flip_count_o  = flip_q;
  assign level_o       = level_q;
endmodule
